mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and load/store port.
- Sits between rv_core and the SoC memory.
- Runs a grant FSM with registered address/data capture, a variable-latency ack handshake, fetch-starvation protection and an ack timeout with sticky error.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced.
- TIMEOUT, 15, cycles in a busy state without mem_ack before the access is aborted.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low (reset==0 resets on next clk edge).
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word, valid when if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_valid.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, valid when d_valid.
- d_valid  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, sampled with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- States: ARB_IDLE, ARB_FETCH, ARB_DATA.
- Reset (any state, mid-access included): state=ARB_IDLE; mem_req/mem_we/if_valid/d_valid/bus_err=0; mem_addr/mem_wdata/if_rdata/d_rdata=0; wait and streak counters=0.
- ARB_IDLE arbitration:
  - Eligible requester: req=1 and its valid=0 in that cycle. The completing requester is masked for one cycle.
  - Data has priority over fetch.
  - Exception: if streak==STARVE_LIMIT and fetch is eligible, fetch wins.
- On grant: register address, we and wdata into mem_*; set mem_req=1 from the next cycle; enter ARB_FETCH or ARB_DATA.
  - Fetch grant forces mem_we=0 and mem_wdata=0.
  - Fetch grant clears streak; data grant increments streak, saturating at STARVE_LIMIT.
- Busy states:
  - mem_req and mem_* outputs are held constant until mem_ack or timeout.
  - Wait counter increments each busy cycle without ack.
- On mem_ack in a busy state:
  - Capture mem_rdata into if_rdata (fetch) or into d_rdata (load only; d_rdata holds for stores).
  - Pulse the matching valid the next cycle; clear mem_req; go to ARB_IDLE; clear wait counter.
- Minimum cost: grant cycle, then ack at the earliest in the first busy cycle, then a valid/IDLE cycle. Three cycles per access at zero wait.
- Timeout: wait counter reaching TIMEOUT with no ack:
  - Drop mem_req; set bus_err=1 (sticky until reset).
  - Load rdata with ABORT_WORD (32'hDEAD_BEEF); pulse valid; go to ARB_IDLE.
- mem_ack while in ARB_IDLE is ignored.
- mem_ack in the same cycle the counter hits TIMEOUT: ack wins, no error.
- Requests arriving while busy wait; no queueing beyond the held req lines.
- if_valid and d_valid are never high together.

Decomposition:
- Package rv_mem_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_FETCH, ARB_DATA}.
  - ABORT_WORD constant.
  - A localparam helper for counter widths ($clog2(TIMEOUT+1), $clog2(STARVE_LIMIT+1)).
- One natural sub-module, arb_wait_timer: clear/enable/expire counter parameterised by TIMEOUT.
- Grant FSM and starvation logic stay in mem_arbiter.

Test Plan:
- Fetch only, addr 0x0000_0010, mem_ack in first busy cycle, rdata 0x0050_0093 -> mem_req one cycle with mem_addr 0x10 and mem_we 0; if_valid pulses with if_rdata 0x0050_0093 three cycles after if_req.
- Simultaneous if_req (0x20) and d_req store (0x100, wdata 0xCAFE_F00D) -> data granted first (mem_we 1, mem_wdata 0xCAFE_F00D); d_valid, then fetch granted; d_rdata unchanged.
- d_req held continuously and if_req held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Fetch granted, mem_ack never asserted -> mem_req drops after 15 busy cycles; if_valid pulses with if_rdata 0xDEAD_BEEF; bus_err=1 and stays 1.
- Ack on the 15th wait cycle with rdata 0x1234_5678 -> normal completion, bus_err stays 0.
- reset=0 asserted during ARB_DATA with mem_req=1 -> next cycle all outputs 0 and state ARB_IDLE; a late mem_ack is ignored; a new fetch after reset completes normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Counter widths are derived from the timing parameters of each instance.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  localparam logic [31:0] ABORT_WORD = 32'hDEAD_BEEF;

  // Bits needed to hold values 0..n
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Busy-cycle counter for the memory arbiter.
// expire_o flags the last enabled cycle before the limit is reached.
module arb_wait_timer
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = cnt_w(TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter in front of a single-port unified memory.
// Data wins by default; a run of data grants eventually yields to fetch.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  localparam int SW = cnt_w(STARVE_LIMIT);

  arb_state_t    state_q;
  logic [SW-1:0] streak_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          if_valid_q;
  logic          d_valid_q;
  logic          bus_err_q;

  logic busy;
  logic expire;
  logic done;
  logic turn_ok;
  logic if_elig;
  logic d_elig;
  logic starve;
  logic gnt_f;
  logic gnt_d;

  assign busy    = (state_q != ARB_IDLE);
  assign done    = busy && (mem_ack || expire);
  // The completion cycle is a turnaround: nothing is granted while a valid pulses
  assign turn_ok = (state_q == ARB_IDLE) && !if_valid_q && !d_valid_q;
  assign if_elig = if_req && !if_valid_q;
  assign d_elig  = d_req && !d_valid_q;
  assign starve  = (streak_q == SW'(STARVE_LIMIT));
  assign gnt_f   = turn_ok && if_elig && (!d_elig || starve);
  assign gnt_d   = turn_ok && d_elig && !gnt_f;

  arb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (!busy || mem_ack),
    .en_i    (busy && !mem_ack),
    .expire_o(expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (gnt_f) begin
            state_q     <= ARB_FETCH;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            streak_q    <= '0;
          end else if (gnt_d) begin
            state_q     <= ARB_DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            streak_q    <= starve ? streak_q : streak_q + SW'(1);
          end
        end
        ARB_FETCH, ARB_DATA: begin
          if (done) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_ack) begin
              bus_err_q <= 1'b1;
            end
            if (state_q == ARB_FETCH) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : DW'(ABORT_WORD);
            end else begin
              d_valid_q <= 1'b1;
              if (!mem_ack) begin
                d_rdata_q <= DW'(ABORT_WORD);
              end else if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int TO  = 15;
  localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no completion within cycle budget", nm);
  endtask

  function automatic logic [159:0] raw();
    return 160'({mem_req, mem_we, mem_addr, mem_wdata, if_valid,
                 if_rdata, d_valid, d_rdata, bus_err});
  endfunction

  function automatic logic [159:0] obs();
    return 160'({mem_req, mem_req & mem_we,
                 mem_req ? mem_addr : 32'h0,
                 mem_req ? mem_wdata : 32'h0,
                 if_valid, if_rdata, d_valid, d_rdata, bus_err});
  endfunction

  // Memory responder: acks after r_lat busy cycles, r_lat==0 never acks
  int          r_lat = 1;
  int          r_cnt = 0;
  logic [31:0] r_data = 32'h0;

  task automatic cyc();
    if (mem_req === 1'b1) begin
      r_cnt++;
      mem_ack = (r_lat != 0) && (r_cnt == r_lat);
    end else begin
      r_cnt   = 0;
      mem_ack = 1'b0;
    end
    mem_rdata = mem_ack ? r_data : $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  typedef struct {
    bit          dat;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    bit seen = 1'b0;
    bit done = 1'b0;
    r_lat  = v.lat;
    r_data = v.rd;
    if (v.dat) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wd;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_req && !seen) begin
        seen = 1'b1;
        chk({nm, " gcyc"}, 160'(c), 160'(1));
        chk({nm, " mem"}, 160'({mem_we, mem_addr, mem_wdata}),
            160'({v.dat & v.we, v.addr, (v.dat ? v.wd : 32'h0)}));
      end
      if (v.dat ? d_valid : if_valid) begin
        done = 1'b1;
        chk({nm, " cyc"}, 160'(c), 160'(v.exp_cyc));
        chk({nm, " rdata"}, 160'(v.dat ? d_rdata : if_rdata),
            160'(v.exp_rd));
        chk({nm, " flags"}, 160'({if_valid & d_valid, bus_err}), 160'(0));
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      cyc();
    end
    if (!done) bound_fail(nm);
  endtask

  // Reference model state (transaction view of the arbiter)
  int          m_own, m_age, m_lat, m_streak;
  bit          m_req, m_we, m_ifv, m_dv, m_err;
  logic [31:0] m_addr, m_wd, m_ifr, m_dr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit [9:0] g;
    int n, both, hi;
    bit pr, done, ifp, dp, n_ifv, n_dv;

    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    do_reset();
    chk("reset", raw(), 160'(0));

    vt[0] = '{0, 0, 32'h10, 0, 1, 32'h0050_0093, 32'h0050_0093, 2};
    vt[1] = '{1, 0, 32'h200, 0, 3, 32'h1111_2222, 32'h1111_2222, 4};
    vt[2] = '{1, 1, 32'h204, 32'hA5A5_A5A5, 2, 32'hFFFF_0000,
              32'h1111_2222, 3};
    vt[3] = '{0, 0, 32'h14, 0, 15, 32'h1234_5678, 32'h1234_5678, 16};
    vt[4] = '{1, 0, 32'h0, 0, 15, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 16};
    vt[5] = '{0, 0, 32'hFFFF_FFFC, 0, 7, 32'h13, 32'h13, 8};
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Simultaneous store and fetch: data first, turnaround, then fetch
    r_lat = 1; r_data = 32'h77;
    if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    cyc();
    chk("sim d grant", 160'({mem_req, mem_we, mem_addr, mem_wdata}),
        160'({2'b11, 32'h100, 32'hCAFE_F00D}));
    cyc();
    chk("sim d valid", 160'({d_valid, if_valid, d_rdata}),
        160'({2'b10, 32'h0BAD_C0DE}));
    d_req = 0;
    cyc();
    chk("sim turn", 160'({mem_req, d_valid, if_valid}), 160'(0));
    cyc();
    chk("sim f grant", 160'({mem_req, mem_we, mem_addr, mem_wdata}),
        160'({2'b10, 32'h20, 32'h0}));
    cyc();
    chk("sim f valid", 160'({if_valid, d_valid, if_rdata, d_rdata}),
        160'({2'b10, 32'h77, 32'h0BAD_C0DE}));
    if_req = 0;
    cyc();

    // Starvation: both held, expect D,D,D,D,F,D,D,D,D,F
    r_lat = 1;
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    g = '0; n = 0; both = 0; pr = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      if (mem_req && !pr) begin
        g[n] = (mem_addr == 32'h40);
        n++;
      end
      if (if_valid && d_valid) both++;
      pr = mem_req;
      cyc();
    end
    chk("starve order", 160'({n, g}), 160'({32'd10, 10'b10_0001_0000}));
    chk("starve excl", 160'(both), 160'(0));
    if_req = 0; d_req = 0;
    repeat (4) cyc();

    // Fetch timeout
    r_lat = 0;
    if_req = 1; if_addr = 32'h30;
    hi = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (mem_req) begin
        hi++;
        if (hi == TO) chk("to err late", 160'(bus_err), 160'(0));
      end
      if (if_valid) begin
        done = 1;
        chk("to len", 160'(hi), 160'(TO));
        chk("to data", 160'({if_rdata, bus_err, d_valid, mem_req}),
            160'({ABORT, 3'b100}));
        if_req = 0;
      end
      cyc();
    end
    if (!done) bound_fail("to");
    repeat (5) cyc();
    chk("to sticky", 160'(bus_err), 160'(1));

    // Reset during a data access
    do_reset();
    chk("reset2", raw(), 160'(0));
    r_lat = 0;
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1;
    repeat (3) cyc();
    chk("rst busy", 160'({mem_req, mem_we}), 160'(2'b11));
    reset = 0; d_req = 0;
    cyc();
    chk("rst mid", raw(), 160'(0));
    reset = 1;
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    mem_ack = 0;
    chk("late ack", raw(), 160'(0));
    run_vec('{0, 0, 32'h44, 0, 2, 32'h99, 32'h99, 3}, "post rst");

    // Randomized run against the reference model
    do_reset();
    m_own = 0; m_age = 0; m_lat = 0; m_streak = 0;
    m_req = 0; m_we = 0; m_ifv = 0; m_dv = 0; m_err = 0;
    m_addr = 0; m_wd = 0; m_ifr = 0; m_dr = 0;
    ifp = 0; dp = 0;
    for (int t = 0; t < 3000; t++) begin
      chk($sformatf("rand t%0d", t), obs(),
          160'({m_req, m_req & m_we,
                m_req ? m_addr : 32'h0, m_req ? m_wd : 32'h0,
                m_ifv, m_ifr, m_dv, m_dr, m_err}));
      if (m_ifv || !ifp) begin
        if (m_ifv || $urandom_range(0, 2) == 0) begin
          ifp = 1'($urandom_range(0, 1)) | !m_ifv;
          if_addr = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (m_dv || !dp) begin
        if (m_dv || $urandom_range(0, 2) == 0) begin
          dp = 1'($urandom_range(0, 1)) | !m_dv;
          d_we = 1'($urandom_range(0, 1));
          d_addr = $urandom & 32'hFFFF_FFFC;
          d_wdata = $urandom;
        end
      end
      if_req = ifp;
      d_req  = dp;
      if (m_own != 0) mem_ack = (m_age == m_lat);
      else mem_ack = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;

      n_ifv = 0; n_dv = 0;
      if (m_own == 0) begin
        if (!m_ifv && !m_dv && (if_req || d_req)) begin
          if (if_req && (!d_req || m_streak == LIM)) begin
            m_own = 1; m_addr = if_addr; m_we = 0; m_wd = 0;
            m_streak = 0;
          end else begin
            m_own = 2; m_addr = d_addr; m_we = d_we; m_wd = d_wdata;
            m_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
          end
          m_req = 1; m_age = 1;
          m_lat = ($urandom_range(0, 19) == 0) ? 20
                : int'($urandom_range(1, TO));
        end
      end else if (mem_ack || m_age == TO) begin
        if (m_own == 1) begin
          n_ifv = 1;
          m_ifr = mem_ack ? mem_rdata : ABORT;
        end else begin
          n_dv = 1;
          if (!mem_ack) m_dr = ABORT;
          else if (!m_we) m_dr = mem_rdata;
        end
        if (!mem_ack) m_err = 1;
        m_own = 0; m_req = 0;
      end else begin
        m_age++;
      end
      m_ifv = n_ifv;
      m_dv  = n_dv;
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
